// File: rtl/float_round_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : float_round_pipe_if
//  Purpose  : Valid/ready operand and result bundle for float_round_pipe.
//  Revision : 1.0  initial release
// ============================================================================
interface float_round_pipe_if #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int MODE_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [MANT_W-1:0] in_mant;
    logic              in_r;
    logic              in_s;
    logic [MODE_W-1:0] in_mode;
    logic              in_inf;
    logic              in_nan;
    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [EXP_W-1:0]  out_exp;
    logic [MANT_W-1:0] out_mant;
    logic              out_inexact;
    logic              out_overflow;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_r, in_s, in_mode,
               in_inf, in_nan, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_mant,
               out_inexact, out_overflow
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_r, in_s, in_mode,
               in_inf, in_nan, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_mant,
               out_inexact, out_overflow
    );
endinterface
`default_nettype wire

// File: rtl/float_round_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : float_round_pipe
//  Purpose  : Two-stage elastic IEEE-754 rounding stage, five rounding modes.
//             Optional sticky status register enabled by FROUND_STATUS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module float_round_pipe #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int MODE_W = 3
) (
    input  logic              Clock,
    input  logic              Reset_n,
    float_round_pipe_if.slave bus
`ifdef FROUND_STATUS_EN
    ,
    input  logic              status_clr,
    output logic [1:0]        status
`endif
);

    localparam logic [MODE_W-1:0] c_MODE_RTZ = MODE_W'(1);
    localparam logic [MODE_W-1:0] c_MODE_RDN = MODE_W'(2);
    localparam logic [MODE_W-1:0] c_MODE_RUP = MODE_W'(3);
    localparam logic [MODE_W-1:0] c_MODE_RMM = MODE_W'(4);

    localparam logic [EXP_W-1:0]  c_EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0]  c_EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [EXP_W:0]    c_EXP_OVF  = {1'b0, {EXP_W{1'b1}}};
    localparam logic [MANT_W-1:0] c_MANT_ONE = {1'b1, {(MANT_W-1){1'b0}}};
    localparam logic [MANT_W-1:0] c_MANT_QNAN = {2'b11, {(MANT_W-2){1'b0}}};

    // Stage 1 registers
    logic              r_s1_valid;
    logic              r_s1_sign;
    logic [EXP_W-1:0]  r_s1_exp;
    logic [MANT_W-1:0] r_s1_mant;
    logic              r_s1_inc;
    logic [MODE_W-1:0] r_s1_mode;
    logic              r_s1_inf;
    logic              r_s1_nan;
    logic              r_s1_inexact;

    // Stage 2 (output) registers
    logic              r_s2_valid;
    logic              r_out_sign;
    logic [EXP_W-1:0]  r_out_exp;
    logic [MANT_W-1:0] r_out_mant;
    logic              r_out_inexact;
    logic              r_out_overflow;

    logic              w_s2_adv;
    logic              w_s1_adv;
    logic              w_in_fire;
    logic              w_rs;
    logic              w_inc;
    logic [MANT_W:0]   w_sum;
    logic [EXP_W:0]    w_exp_rnd;
    logic [MANT_W-1:0] w_mant_rnd;
    logic              w_ovf;
    logic              w_to_inf;
    logic [EXP_W-1:0]  w_res_exp;
    logic [MANT_W-1:0] w_res_mant;
    logic              w_res_inexact;
    logic              w_res_overflow;

    assign w_s2_adv     = !r_s2_valid | bus.out_ready;
    assign w_s1_adv     = !r_s1_valid | w_s2_adv;
    assign w_in_fire    = bus.in_valid & w_s1_adv;
    assign bus.in_ready = w_s1_adv;

    // Increment decision; unassigned mode codes fall back to round-half-even.
    always_comb begin
        w_rs  = bus.in_r | bus.in_s;
        w_inc = 1'b0;
        case (bus.in_mode)
            c_MODE_RTZ: w_inc = 1'b0;
            c_MODE_RDN: w_inc = bus.in_sign & w_rs;
            c_MODE_RUP: w_inc = !bus.in_sign & w_rs;
            c_MODE_RMM: w_inc = bus.in_r;
            default:    w_inc = bus.in_r & (bus.in_s | bus.in_mant[0]);
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_exp     <= '0;
            r_s1_mant    <= '0;
            r_s1_inc     <= 1'b0;
            r_s1_mode    <= '0;
            r_s1_inf     <= 1'b0;
            r_s1_nan     <= 1'b0;
            r_s1_inexact <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= bus.in_valid;
            end
            if (w_in_fire) begin
                r_s1_sign    <= bus.in_sign;
                r_s1_exp     <= bus.in_exp;
                r_s1_mant    <= bus.in_mant;
                r_s1_inc     <= w_inc;
                r_s1_mode    <= bus.in_mode;
                r_s1_inf     <= bus.in_inf;
                r_s1_nan     <= bus.in_nan;
                r_s1_inexact <= w_rs;
            end
        end
    end

    // Carry out of the mantissa renormalises to 1.000... and bumps the exponent.
    assign w_sum      = {1'b0, r_s1_mant} + {{MANT_W{1'b0}}, r_s1_inc};
    assign w_exp_rnd  = {1'b0, r_s1_exp} + {{EXP_W{1'b0}}, w_sum[MANT_W]};
    assign w_mant_rnd = w_sum[MANT_W] ? c_MANT_ONE : w_sum[MANT_W-1:0];
    assign w_ovf      = (w_exp_rnd >= c_EXP_OVF);

    always_comb begin
        w_to_inf = 1'b1;
        case (r_s1_mode)
            c_MODE_RTZ: w_to_inf = 1'b0;
            c_MODE_RDN: w_to_inf = r_s1_sign;
            c_MODE_RUP: w_to_inf = !r_s1_sign;
            default:    w_to_inf = 1'b1;
        endcase
    end

    always_comb begin
        w_res_exp      = w_exp_rnd[EXP_W-1:0];
        w_res_mant     = w_mant_rnd;
        w_res_inexact  = r_s1_inexact;
        w_res_overflow = 1'b0;
        if (r_s1_nan) begin
            w_res_exp     = c_EXP_ONES;
            w_res_mant    = c_MANT_QNAN;
            w_res_inexact = 1'b0;
        end else if (r_s1_inf) begin
            w_res_exp     = c_EXP_ONES;
            w_res_mant    = '0;
            w_res_inexact = 1'b0;
        end else if (w_ovf) begin
            w_res_overflow = 1'b1;
            w_res_inexact  = 1'b1;
            if (w_to_inf) begin
                w_res_exp  = c_EXP_ONES;
                w_res_mant = '0;
            end else begin
                w_res_exp  = c_EXP_MAXF;
                w_res_mant = {MANT_W{1'b1}};
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_s2_valid     <= 1'b0;
            r_out_sign     <= 1'b0;
            r_out_exp      <= '0;
            r_out_mant     <= '0;
            r_out_inexact  <= 1'b0;
            r_out_overflow <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_sign     <= r_s1_sign;
                r_out_exp      <= w_res_exp;
                r_out_mant     <= w_res_mant;
                r_out_inexact  <= w_res_inexact;
                r_out_overflow <= w_res_overflow;
            end
        end
    end

    assign bus.out_valid    = r_s2_valid;
    assign bus.out_sign     = r_out_sign;
    assign bus.out_exp      = r_out_exp;
    assign bus.out_mant     = r_out_mant;
    assign bus.out_inexact  = r_out_inexact;
    assign bus.out_overflow = r_out_overflow;

`ifdef FROUND_STATUS_EN
    logic       w_emit;
    logic [1:0] r_status;

    assign w_emit = r_s2_valid & bus.out_ready;

    // An emitting beat's flags survive a coincident clear.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_status <= 2'b00;
        end else if (w_emit) begin
            r_status <= (status_clr ? 2'b00 : r_status) | {r_out_overflow, r_out_inexact};
        end else if (status_clr) begin
            r_status <= 2'b00;
        end
    end

    assign status = r_status;
`endif

endmodule
`default_nettype wire

// File: tb/tb_float_round_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_float_round_pipe
//  Purpose  : Directed self-checking bench for float_round_pipe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_float_round_pipe;

    logic Clock;
    logic Reset_n;
    int   n_checks;
    int   n_errors;

    float_round_pipe_if #(.MANT_W(24), .EXP_W(8), .MODE_W(3)) bus ();

`ifdef FROUND_STATUS_EN
    logic       status_clr;
    logic [1:0] status;
`endif

    float_round_pipe #(.MANT_W(24), .EXP_W(8), .MODE_W(3)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
`ifdef FROUND_STATUS_EN
        ,
        .status_clr (status_clr),
        .status     (status)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Single isolated beat: accept, confirm 2-cycle latency, compare result.
    task automatic run_op(input string tag,
                          input logic sg, input logic [7:0] ex, input logic [23:0] mt,
                          input logic r, input logic s, input logic [2:0] md,
                          input logic inf, input logic nan,
                          input logic e_sg, input logic [7:0] e_ex, input logic [23:0] e_mt,
                          input logic e_inx, input logic e_ovf);
        @(negedge Clock);
        bus.in_valid  = 1'b1;
        bus.in_sign   = sg;
        bus.in_exp    = ex;
        bus.in_mant   = mt;
        bus.in_r      = r;
        bus.in_s      = s;
        bus.in_mode   = md;
        bus.in_inf    = inf;
        bus.in_nan    = nan;
        bus.out_ready = 1'b1;
        #1;
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        @(negedge Clock);
        bus.in_valid = 1'b0;
        check({tag, ".lat1"}, 32'(bus.out_valid), 32'd0);
        @(negedge Clock);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".res"},
              {3'b0, bus.out_sign, bus.out_exp, bus.out_mant},
              {3'b0, e_sg, e_ex, e_mt});
        check({tag, ".flags"}, {30'b0, bus.out_overflow, bus.out_inexact}, {30'b0, e_ovf, e_inx});
    endtask

    logic [31:0] bp_exp [4];
    logic [31:0] held;
    logic        prev_stall;
    logic        saw_stall;
    logic        seen_out;
    int          sent;
    int          rcvd;

    initial begin
        n_checks = 0;
        n_errors = 0;
        Reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mant   = '0;
        bus.in_r      = 1'b0;
        bus.in_s      = 1'b0;
        bus.in_mode   = '0;
        bus.in_inf    = 1'b0;
        bus.in_nan    = 1'b0;
        bus.out_ready = 1'b1;
`ifdef FROUND_STATUS_EN
        status_clr = 1'b0;
`endif
        repeat (2) @(negedge Clock);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.in_ready", 32'(bus.in_ready), 32'd1);
        check("rst.data", {3'b0, bus.out_sign, bus.out_exp, bus.out_mant}, 32'd0);
        check("rst.flags", {30'b0, bus.out_overflow, bus.out_inexact}, 32'd0);
`ifdef FROUND_STATUS_EN
        check("rst.status", 32'(status), 32'd0);
`endif
        Reset_n = 1'b1;

        run_op("rne_tie_up",   0, 8'h40, 24'h000003, 1, 0, 3'b000, 0, 0, 0, 8'h40, 24'h000004, 1, 0);
        run_op("rne_tie_even", 0, 8'h40, 24'h000002, 1, 0, 3'b000, 0, 0, 0, 8'h40, 24'h000002, 1, 0);
        run_op("rup_carry",    0, 8'h7E, 24'hFFFFFF, 1, 0, 3'b011, 0, 0, 0, 8'h7F, 24'h800000, 1, 0);
        run_op("rne_ovf",      0, 8'hFE, 24'hFFFFFF, 1, 1, 3'b000, 0, 0, 0, 8'hFF, 24'h000000, 1, 1);
        run_op("rtz_no_ovf",   0, 8'hFE, 24'hFFFFFF, 1, 1, 3'b001, 0, 0, 0, 8'hFE, 24'hFFFFFF, 1, 0);
        run_op("rdn_pos_ovf",  0, 8'hFF, 24'h800000, 1, 0, 3'b010, 0, 0, 0, 8'hFE, 24'hFFFFFF, 1, 1);
        run_op("rdn_neg_ovf",  1, 8'hFE, 24'hFFFFFF, 0, 1, 3'b010, 0, 0, 1, 8'hFF, 24'h000000, 1, 1);
        run_op("rup_neg_ovf",  1, 8'hFF, 24'hC00000, 0, 1, 3'b011, 0, 0, 1, 8'hFE, 24'hFFFFFF, 1, 1);
        run_op("rmm_ovf",      0, 8'hFE, 24'hFFFFFF, 1, 0, 3'b100, 0, 0, 0, 8'hFF, 24'h000000, 1, 1);
        run_op("rmm_tie",      0, 8'h10, 24'h000002, 1, 0, 3'b100, 0, 0, 0, 8'h10, 24'h000003, 1, 0);
        run_op("rdn_neg_s",    1, 8'h10, 24'h000010, 0, 1, 3'b010, 0, 0, 1, 8'h10, 24'h000011, 1, 0);
        run_op("rup_pos_s",    0, 8'h22, 24'h400000, 0, 1, 3'b011, 0, 0, 0, 8'h22, 24'h400001, 1, 0);
        run_op("mode7_rne",    0, 8'h20, 24'h000001, 1, 0, 3'b111, 0, 0, 0, 8'h20, 24'h000002, 1, 0);
        run_op("exact",        0, 8'h80, 24'h123456, 0, 0, 3'b000, 0, 0, 0, 8'h80, 24'h123456, 0, 0);
        run_op("nan_inf",      1, 8'h12, 24'h800000, 1, 1, 3'b000, 1, 1, 1, 8'hFF, 24'hC00000, 0, 0);
        run_op("inf",          0, 8'h00, 24'h000000, 1, 1, 3'b011, 1, 0, 0, 8'hFF, 24'h000000, 0, 0);
        run_op("neg_zero",     1, 8'h00, 24'h000000, 0, 0, 3'b000, 0, 0, 1, 8'h00, 24'h000000, 0, 0);

        // Backpressure: four beats, out_ready low for three cycles mid-stream.
        for (int i = 0; i < 4; i++) bp_exp[i] = {8'h00, 8'h50 + 8'(i), 24'h000100 + 24'(i)};
        sent = 0; rcvd = 0; prev_stall = 1'b0; saw_stall = 1'b0; held = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge Clock);
            bus.out_ready = !(cyc >= 3 && cyc <= 5);
            bus.in_valid  = (sent < 4);
            bus.in_sign   = 1'b0;
            bus.in_exp    = 8'h50 + 8'(sent);
            bus.in_mant   = 24'h000100 + 24'(sent);
            bus.in_r      = 1'b1;
            bus.in_s      = 1'b0;
            bus.in_mode   = 3'b001;
            bus.in_inf    = 1'b0;
            bus.in_nan    = 1'b0;
            #1;
            if (prev_stall) check("bp.stable", {8'h00, bus.out_exp, bus.out_mant}, held);
            if (bus.out_valid && bus.out_ready) begin
                if (rcvd < 4) check("bp.order", {8'h00, bus.out_exp, bus.out_mant}, bp_exp[rcvd]);
                else check("bp.extra", 32'(rcvd), 32'd3);
                rcvd++;
            end
            held       = {8'h00, bus.out_exp, bus.out_mant};
            prev_stall = bus.out_valid & !bus.out_ready;
            if (!bus.in_ready) saw_stall = 1'b1;
            if (bus.in_valid && bus.in_ready) sent++;
        end
        bus.in_valid = 1'b0;
        check("bp.sent", 32'(sent), 32'd4);
        check("bp.rcvd", 32'(rcvd), 32'd4);
        check("bp.in_ready_drop", 32'(saw_stall), 32'd1);

        // Reset with two beats in flight: neither may be emitted.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clock);
            bus.in_valid = 1'b1;
            bus.in_mode  = 3'b000;
            bus.in_exp   = 8'h30;
            bus.in_mant  = 24'h00AA00 + 24'(i);
        end
        @(negedge Clock);
        bus.in_valid = 1'b0;
        Reset_n      = 1'b0;
        @(negedge Clock);
        check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst.in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst.data", {8'h00, bus.out_exp, bus.out_mant}, 32'd0);
        Reset_n       = 1'b1;
        bus.out_ready = 1'b1;
        seen_out      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            if (bus.out_valid) seen_out = 1'b1;
        end
        check("midrst.no_emit", 32'(seen_out), 32'd0);

`ifdef FROUND_STATUS_EN
        run_op("st_inexact", 0, 8'h40, 24'h000002, 1, 0, 3'b000, 0, 0, 0, 8'h40, 24'h000002, 1, 0);
        run_op("st_ovf",     0, 8'hFE, 24'hFFFFFF, 1, 1, 3'b000, 0, 0, 0, 8'hFF, 24'h000000, 1, 1);
        @(negedge Clock);
        check("status.both", 32'(status), 32'd3);
        status_clr = 1'b1;
        @(negedge Clock);
        status_clr = 1'b0;
        check("status.clr_idle", 32'(status), 32'd0);
        @(negedge Clock);
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b0;
        bus.in_exp   = 8'h40;
        bus.in_mant  = 24'h000002;
        bus.in_r     = 1'b1;
        bus.in_s     = 1'b0;
        bus.in_mode  = 3'b000;
        @(negedge Clock);
        bus.in_valid = 1'b0;
        @(negedge Clock);
        check("status.emit_valid", 32'(bus.out_valid), 32'd1);
        status_clr = 1'b1;
        @(negedge Clock);
        status_clr = 1'b0;
        check("status.clr_emit", 32'(status), 32'd1);
`endif

        repeat (2) @(negedge Clock);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
